// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver with mid-bit sampling; feeds an enabled holding register
// through data/valid and flags a low stop bit on frame_err.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state, state_n;
    logic             rx_meta, rx_s;
    logic [1:0]       warm;
    logic             primed, seen_high;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data_n;
    logic             valid_n, frame_err_n, busy_n;

    // Two-flop synchronizer plus a warm-up marker so the line is judged only once rx_s is real.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            warm      <= 2'b00;
            seen_high <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            warm    <= {warm[0], 1'b1};
            if (primed && rx_s) seen_high <= 1'b1;
        end
    end

    assign primed = warm[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // A line found low before it has ever been seen high after reset is parked in BREAK.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (primed && !rx_s) state_n = seen_high ? START : BREAK;
            START: if (cnt == HALF)     state_n = rx_s ? IDLE : DATA;
            DATA:  if (cnt == FULL && idx == 3'd7) state_n = STOP;
            STOP:  if (cnt == FULL)     state_n = rx_s ? IDLE : BREAK;
            BREAK: if (rx_s)            state_n = IDLE;
            default:                    state_n = IDLE;
        endcase
    end

    always_comb begin
        cnt_n       = cnt + CNT_W'(1);
        idx_n       = idx;
        shift_n     = shift;
        data_n      = data;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;
        busy_n      = (state_n != IDLE);
        unique case (state)
            IDLE:  cnt_n = '0;
            START: if (cnt == HALF) begin
                cnt_n = '0;
                idx_n = 3'd0;
            end
            DATA:  if (cnt == FULL) begin
                cnt_n        = '0;
                shift_n[idx] = rx_s;
                idx_n        = idx + 3'd1;
            end
            STOP:  if (cnt == FULL) begin
                cnt_n = '0;
                if (rx_s) begin
                    data_n  = shift;
                    valid_n = 1'b1;
                end else begin
                    frame_err_n = 1'b1;
                end
            end
            BREAK: cnt_n = '0;
            default: cnt_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            idx       <= idx_n;
            shift     <= shift_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
            busy      <= busy_n;
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit: clean frames, back-to-back,
// glitch, framing error with held-low line, reset mid-frame and random idle gaps.
module tb_uart_rx_byte;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid, frame_err, busy;

    int checks   = 0;
    int failures = 0;

    int         cyc = 0;
    int         vcount = 0, fcount = 0, bcount = 0, overlap = 0;
    int         vcyc = 0;
    logic       prev_pulse = 1'b0;
    logic [7:0] vq[$];

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Event logger; samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            vcount = vcount + 1;
            vcyc   = cyc;
            vq.push_back(data);
        end
        if (frame_err) fcount = fcount + 1;
        if (busy) bcount = bcount + 1;
        if ((valid && frame_err) || ((valid || frame_err) && prev_pulse)) overlap = overlap + 1;
        prev_pulse = valid | frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop, CPB);
    endtask

    int         v0, f0, b0, q0, t_drop, t_first, lat, gap;
    logic [7:0] rb;
    logic [7:0] exp_q[$];

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data), 32'h00);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        hold(1'b1, 10);

        // Single clean frame 0xA5
        v0 = vcount; f0 = fcount; q0 = vq.size();
        t_drop = cyc;
        send_byte(8'hA5, 1'b1);
        hold(1'b1, 4);
        check("a5_valid_cycles", 32'(vcount - v0), 32'd1);
        check("a5_data", 32'(vq[q0]), 32'hA5);
        check("a5_ferr", 32'(fcount - f0), 32'd0);
        check("a5_busy_after", 32'(busy), 32'h0);
        lat = vcyc - t_drop - 1;
        check("a5_latency_in_153_155", 32'(lat >= 153 && lat <= 155), 32'h1);

        // Back-to-back 0x00 then 0xFF with no idle gap
        v0 = vcount; q0 = vq.size();
        send_byte(8'h00, 1'b1);
        t_first = vcyc;
        send_byte(8'hFF, 1'b1);
        hold(1'b1, 4);
        check("b2b_count", 32'(vcount - v0), 32'd2);
        check("b2b_first", 32'(vq[q0]), 32'h00);
        check("b2b_second", 32'(vq[q0+1]), 32'hFF);
        check("b2b_spacing", 32'(vcyc - t_first), 32'd160);

        // Short low glitch must be rejected
        v0 = vcount; f0 = fcount; b0 = bcount;
        hold(1'b0, 3);
        hold(1'b1, 30);
        check("glitch_busy_seen", 32'(bcount > b0), 32'h1);
        check("glitch_valid", 32'(vcount - v0), 32'd0);
        check("glitch_ferr", 32'(fcount - f0), 32'd0);
        check("glitch_data", 32'(data), 32'hFF);
        check("glitch_busy_after", 32'(busy), 32'h0);

        // 0x3C with a low stop bit, line held low afterwards
        v0 = vcount; f0 = fcount;
        send_byte(8'h3C, 1'b0);
        hold(1'b0, 50);
        check("ferr_count", 32'(fcount - f0), 32'd1);
        check("ferr_no_valid", 32'(vcount - v0), 32'd0);
        check("ferr_data_kept", 32'(data), 32'hFF);
        check("ferr_busy_while_low", 32'(busy), 32'h1);
        hold(1'b1, 6);
        check("ferr_busy_released", 32'(busy), 32'h0);

        // Reset during bit 4 of 0x81, then a clean 0x81
        hold(1'b1, 10);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        for (int i = 1; i < 4; i++) hold(1'b0, CPB);
        hold(1'b0, 8);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data", 32'(data), 32'h00);
        check("mid_rst_valid", 32'(valid), 32'h0);
        check("mid_rst_ferr", 32'(frame_err), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        v0 = vcount; f0 = fcount;
        hold(1'b0, 4);
        rst_n = 1'b1;
        hold(1'b0, 4);
        check("post_rst_low_busy", 32'(busy), 32'h1);
        hold(1'b0, 4 + 2 * CPB);
        hold(1'b1, 2 * CPB);
        hold(1'b1, 20);
        check("post_rst_no_valid", 32'(vcount - v0), 32'd0);
        q0 = vq.size();
        send_byte(8'h81, 1'b1);
        hold(1'b1, 4);
        check("clean81_count", 32'(vcount - v0), 32'd1);
        check("clean81_data", 32'(vq[q0]), 32'h81);
        check("clean81_ferr", 32'(fcount - f0), 32'd0);

        // Random bytes with random idle gaps
        v0 = vcount; f0 = fcount; q0 = vq.size();
        for (int n = 0; n < 20; n++) begin
            gap = int'($urandom_range(0, 15));
            if (gap > 0) hold(1'b1, gap);
            rb = 8'($urandom);
            exp_q.push_back(rb);
            send_byte(rb, 1'b1);
        end
        hold(1'b1, 20);
        check("rand_count", 32'(vcount - v0), 32'd20);
        check("rand_ferr", 32'(fcount - f0), 32'd0);
        for (int n = 0; n < 20; n++) begin
            if (q0 + n < vq.size()) check($sformatf("rand_byte%0d", n), 32'(vq[q0+n]), 32'(exp_q[n]));
            else check($sformatf("rand_byte%0d_missing", n), 32'd0, 32'd1);
        end

        check("pulse_overlap", 32'(overlap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
